// File: rtl/hornet_stack.sv
// Circular register stack behind the hornet core's top-of-stack registers.
// It wraps in both directions and never blocks. It tracks depth and sets sticky overflow/underflow flags.
module hornet_stack #(
    parameter int             W     = 18,
    parameter int             DEPTH = 8,
    parameter int             AW    = $clog2(DEPTH),
    parameter logic [W-1:0]   FILL  = 18'h15555
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  q,
    output logic [AW:0]   depth,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf,
    input  logic          clr_flags
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr_reg, ptr_next;
    logic [AW:0]   depth_reg, depth_next;
    logic          ovf_reg, unf_reg;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          ovf_event, unf_event;

    always_comb begin
        ptr_next   = ptr_reg;
        depth_next = depth_reg;
        wr_en      = 1'b0;
        wr_addr    = ptr_reg;
        ovf_event  = 1'b0;
        unf_event  = 1'b0;
        case ({push, pop})
            2'b10: begin
                ptr_next  = ptr_reg + 1'b1;
                wr_en     = 1'b1;
                wr_addr   = ptr_reg + 1'b1;
                ovf_event = (depth_reg == FULL_COUNT);
                if (depth_reg != FULL_COUNT)
                    depth_next = depth_reg + 1'b1;
            end
            2'b01: begin
                ptr_next  = ptr_reg - 1'b1;
                unf_event = (depth_reg == '0);
                if (depth_reg != '0)
                    depth_next = depth_reg - 1'b1;
            end
            // Replace top: rewrite in place, depth and flags untouched.
            2'b11: begin
                wr_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= FILL;
        end else if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg   <= '0;
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            depth_reg <= depth_next;
            // A new event in the same cycle as clr_flags still sets the flag.
            ovf_reg   <= ovf_event | (ovf_reg & ~clr_flags);
            unf_reg   <= unf_event | (unf_reg & ~clr_flags);
        end
    end

    assign q     = mem[ptr_reg];
    assign depth = depth_reg;
    assign empty = (depth_reg == '0);
    assign full  = (depth_reg == FULL_COUNT);
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

endmodule

// File: tb/tb_hornet_stack.sv
// Scoreboard bench for hornet_stack: a driver pushes the expected state after each edge into a queue,
// and a negedge monitor pops each entry and compares it against the DUT.
module tb_hornet_stack;

    localparam int           W     = 18;
    localparam int           DEPTH = 8;
    localparam int           AW    = 3;
    localparam logic [W-1:0] FILL  = 18'h15555;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clr_flags = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  q;
    logic [AW:0]   depth;
    logic          empty, full, ovf, unf;

    hornet_stack #(.W(W), .DEPTH(DEPTH), .FILL(FILL)) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(din),
        .q(q), .depth(depth), .empty(empty), .full(full), .ovf(ovf), .unf(unf),
        .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        int           depth;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    // Reference model: the stack as an array, a top index and a count.
    logic [W-1:0] m_mem [DEPTH];
    int           m_ptr, m_depth;
    logic         m_ovf, m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
        m_ptr = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic step(input logic p, input logic o, input logic [W-1:0] d, input logic c);
        exp_t e;
        logic ev_o, ev_u;
        push = p; pop = o; din = d; clr_flags = c;
        @(posedge clk);
        #1;
        ev_o = 1'b0; ev_u = 1'b0;
        if (p && !o) begin
            ev_o = (m_depth == DEPTH);
            m_ptr = (m_ptr + 1) % DEPTH;
            m_mem[m_ptr] = d;
            if (m_depth < DEPTH) m_depth++;
        end else if (o && !p) begin
            ev_u = (m_depth == 0);
            m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
            if (m_depth > 0) m_depth--;
        end else if (p && o) begin
            m_mem[m_ptr] = d;
        end
        if (c) begin
            m_ovf = ev_o; m_unf = ev_u;
        end else begin
            m_ovf = m_ovf | ev_o; m_unf = m_unf | ev_u;
        end
        e.q = m_mem[m_ptr]; e.depth = m_depth; e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        push = 1'b0; pop = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q"},     32'(q),     32'(FILL));
        check({tag, "_depth"}, 32'(depth), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"},  32'(full),  32'd0);
        check({tag, "_ovf"},   32'(ovf),   32'd0);
        check({tag, "_unf"},   32'(unf),   32'd0);
    endtask

    // Reset is asserted and checked between edges, so it must act without a clock.
    task automatic do_reset(input string tag);
        drain();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("q",     32'(q),     32'(mon_e.q));
            check("depth", 32'(depth), 32'(mon_e.depth));
            check("empty", 32'(empty), 32'(mon_e.depth == 0));
            check("full",  32'(full),  32'(mon_e.depth == DEPTH));
            check("ovf",   32'(ovf),   32'(mon_e.ovf));
            check("unf",   32'(unf),   32'(mon_e.unf));
            $display("txn q=%05h depth=%0d ovf=%0b unf=%0b", q, depth, ovf, unf);
        end
    end

    initial begin
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        #1 reset_n = 1'b1;

        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, W'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0);

        do_reset("rst_a");
        for (int i = 10; i <= 18; i++) step(1'b1, 1'b0, W'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);
        drain();
        check("wrap_q", 32'(q), 32'd18);

        do_reset("rst_b");
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        drain();
        check("unf_wins_clr", 32'(unf), 32'd1);

        do_reset("rst_c");
        step(1'b1, 1'b0, W'(5), 1'b0);
        step(1'b1, 1'b1, W'(7), 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, W'(9), 1'b0);

        do_reset("rst_d");
        step(1'b1, 1'b0, 18'h3FFFF, 1'b0);
        step(1'b1, 1'b0, 18'h20000, 1'b0);
        do_reset("async");

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 W'($urandom), ($urandom_range(0, 9) == 0));
            if (n % 200 == 199) do_reset("rst_rand");
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
